// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, drives the program memory
// address and registers the returned word with a valid flag for decode.
module fetch_unit #(
    parameter int p_size = 6,
    parameter int i_size = 24,
    parameter logic [i_size-1:0] HALT_WORD = {i_size{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_abs,
    input  logic              branch_rel,
    input  logic [p_size-1:0] branch_target,
    input  logic [p_size-1:0] branch_offset,
    input  logic [i_size-1:0] mem_instr,
    output logic [p_size-1:0] address,
    output logic [i_size-1:0] instr_out,
    output logic [p_size-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [p_size-1:0] PC_ONE = {{(p_size-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [p_size-1:0] pc, pc_nxt;
    logic [i_size-1:0] instr_out_nxt;
    logic [p_size-1:0] instr_pc_nxt;
    logic              instr_valid_nxt;

    assign address = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_out   <= instr_out_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
            halted      <= (state_nxt == HALT);
        end
    end

    // A branch only counts when the issued word is live; it kills the word
    // currently at pc, giving the single bubble cycle.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_out_nxt   = instr_out;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        case (state)
            IDLE: begin
                instr_valid_nxt = 1'b0;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (instr_valid && (branch_abs || branch_rel)) begin
                    pc_nxt          = branch_abs ? branch_target : (instr_pc + branch_offset);
                    instr_valid_nxt = 1'b0;
                end else if (stall) begin
                    pc_nxt = pc;
                end else if (mem_instr == HALT_WORD) begin
                    state_nxt       = HALT;
                    instr_valid_nxt = 1'b0;
                end else begin
                    instr_out_nxt   = mem_instr;
                    instr_pc_nxt    = pc;
                    instr_valid_nxt = 1'b1;
                    pc_nxt          = pc + PC_ONE;
                end
            end
            HALT: begin
                instr_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt       = IDLE;
                instr_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts every cycle,
// a monitor compares DUT outputs against the queued predictions.
module tb_fetch_unit;

    localparam int P = 6;
    localparam int I = 24;
    localparam logic [I-1:0] HALT_WORD = {I{1'b1}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         stall = 1'b0;
    logic         branch_abs = 1'b0;
    logic         branch_rel = 1'b0;
    logic [P-1:0] branch_target = '0;
    logic [P-1:0] branch_offset = '0;
    logic [I-1:0] mem_instr;
    logic [P-1:0] address;
    logic [I-1:0] instr_out;
    logic [P-1:0] instr_pc;
    logic         instr_valid;
    logic         halted;

    logic [I-1:0] mem [64];

    typedef struct packed {
        logic [P-1:0] addr;
        logic         halted;
        logic         valid;
    } status_t;

    typedef struct packed {
        logic [I-1:0] instr;
        logic [P-1:0] pc;
    } issue_t;

    status_t status_q[$];
    issue_t  issue_q[$];

    int total = 0;
    int bad = 0;

    bit           m_running, m_halted, m_valid;
    logic [P-1:0] m_pc, m_ipc;
    logic [I-1:0] m_iout;

    fetch_unit #(.p_size(P), .i_size(I), .HALT_WORD(HALT_WORD)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_abs(branch_abs), .branch_rel(branch_rel),
        .branch_target(branch_target), .branch_offset(branch_offset),
        .mem_instr(mem_instr), .address(address), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
    );

    assign mem_instr = mem[address];

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_clear();
        m_running = 0; m_halted = 0; m_valid = 0;
        m_pc = '0; m_ipc = '0; m_iout = '0;
    endtask

    // Called at a negedge: drive inputs, predict the coming edge, queue the result.
    task automatic apply_stimulus(input logic st, input logic sl, input logic ba, input logic br,
                                  input logic [P-1:0] tgt, input logic [P-1:0] off);
        start = st; stall = sl; branch_abs = ba; branch_rel = br;
        branch_target = tgt; branch_offset = off;
        if (m_halted) begin
        end else if (!m_running) begin
            if (st) m_running = 1;
        end else if (m_valid && (ba || br)) begin
            m_pc    = ba ? tgt : P'(m_ipc + off);
            m_valid = 0;
        end else if (sl) begin
        end else if (mem[m_pc] == HALT_WORD) begin
            m_halted = 1;
            m_valid  = 0;
        end else begin
            m_iout  = mem[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = P'(m_pc + 1);
        end
        status_q.push_back('{addr: m_pc, halted: m_halted, valid: m_valid});
        if (m_valid) issue_q.push_back('{instr: m_iout, pc: m_ipc});
        @(negedge clk);
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(0, 0, 0, 0, '0, '0);
    endtask

    // Reset is raised in the middle of the low phase and checked before any edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        start = 0; stall = 0; branch_abs = 0; branch_rel = 0;
        #1;
        check_output("rst_address", address, 0);
        check_output("rst_instr_out", instr_out, 0);
        check_output("rst_instr_pc", instr_pc, 0);
        check_output("rst_instr_valid", instr_valid, 0);
        check_output("rst_halted", halted, 0);
        status_q.delete();
        issue_q.delete();
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_mem(input int halt_chance);
        for (int k = 0; k < 64; k++) begin
            mem[k] = I'($urandom);
            if (mem[k] == HALT_WORD) mem[k] = '0;
            if (halt_chance > 0 && $urandom_range(0, halt_chance - 1) == 0) mem[k] = HALT_WORD;
        end
    endtask

    initial begin : monitor
        status_t s;
        issue_t  e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && status_q.size() > 0) begin
                s = status_q.pop_front();
                check_output("address", address, s.addr);
                check_output("halted", halted, s.halted);
                check_output("instr_valid", instr_valid, s.valid);
                if (instr_valid) begin
                    if (issue_q.size() > 0) begin
                        e = issue_q.pop_front();
                        check_output("instr_out", instr_out, e.instr);
                        check_output("instr_pc", instr_pc, e.pc);
                    end else begin
                        check_output("issue_q_depth", issue_q.size(), 1);
                    end
                end
            end
        end
    end

    initial begin : driver
        model_clear();
        fill_mem(0);
        @(negedge clk);

        // start-up and a run long enough to wrap the pc
        do_reset();
        apply_stimulus(1, 0, 0, 0, '0, '0);
        run_idle(70);

        // stall while instr_pc=4
        do_reset();
        apply_stimulus(1, 0, 0, 0, '0, '0);
        run_idle(5);
        check_output("stall_pre_pc", instr_pc, 4);
        for (int k = 0; k < 3; k++) apply_stimulus(0, 1, 0, 0, '0, '0);
        check_output("stall_hold_addr", address, 5);
        run_idle(2);

        // absolute branch from instr_pc=3 to 0x20
        do_reset();
        apply_stimulus(1, 0, 0, 0, '0, '0);
        run_idle(4);
        apply_stimulus(0, 0, 1, 0, 6'h20, '0);
        run_idle(3);
        // relative branch -2 from instr_pc=1, both together, branch under stall
        do_reset();
        apply_stimulus(1, 0, 0, 0, '0, '0);
        run_idle(2);
        apply_stimulus(0, 0, 0, 1, 6'h11, 6'h3E);
        run_idle(3);
        apply_stimulus(0, 0, 1, 1, 6'h10, 6'h05);
        run_idle(2);
        apply_stimulus(0, 1, 1, 0, 6'h08, '0);
        apply_stimulus(0, 1, 0, 0, '0, '0);
        run_idle(3);

        // halt word at 7
        mem[7] = HALT_WORD;
        do_reset();
        apply_stimulus(1, 0, 0, 0, '0, '0);
        run_idle(10);
        for (int k = 0; k < 10; k++) apply_stimulus(1, 0, 1, 0, 6'h02, '0);
        check_output("halt_addr", address, 7);
        check_output("halt_flag", halted, 1);
        do_reset();
        run_idle(3);
        mem[7] = 24'h000123;

        // reset during a branch bubble
        do_reset();
        apply_stimulus(1, 0, 0, 0, '0, '0);
        run_idle(3);
        apply_stimulus(0, 0, 1, 0, 6'h30, '0);
        do_reset();
        run_idle(3);
        apply_stimulus(1, 0, 0, 0, '0, '0);
        run_idle(3);

        // randomized episodes
        for (int ep = 0; ep < 6; ep++) begin
            fill_mem(40);
            do_reset();
            for (int k = 0; k < 150; k++) begin
                apply_stimulus($urandom_range(0, 3) == 0,
                               $urandom_range(0, 3) == 0,
                               $urandom_range(0, 7) == 0,
                               $urandom_range(0, 7) == 0,
                               P'($urandom), P'($urandom));
            end
        end

        check_output("status_q_empty", status_q.size(), 0);
        check_output("issue_q_empty", issue_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the program memory. Holds the program counter and drives the memory read address. Latches the returned instruction word into an instruction register with a valid flag for the decode/execute stage. Handles start-up, stalls, absolute/relative branch redirection with a one-cycle flush, and a halt word that freezes fetch until reset.

## Interface
- `p_size`, 6: program address width; memory depth is 2^p_size words.
- `i_size`, 24: instruction width.
- `HALT_WORD`, {i_size{1'b1}}: instruction encoding that halts fetch.

- `clk` input 1: clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: leaves IDLE; ignored in RUN and HALT.
- `stall` input 1: downstream not ready; freeze pc and instruction register.
- `branch_abs` input 1: redirect to `branch_target`.
- `branch_rel` input 1: redirect to `instr_pc + branch_offset`.
- `branch_target` input p_size: absolute target.
- `branch_offset` input p_size: two's-complement relative offset.
- `mem_instr` input i_size: word returned combinationally by program memory for `address`.
- `address` output p_size: program memory read address; equals pc combinationally.
- `instr_out` output i_size: instruction register.
- `instr_pc` output p_size: address from which `instr_out` was fetched.
- `instr_valid` output 1: `instr_out` is a live instruction for downstream.
- `halted` output 1: fetch stopped by HALT_WORD.

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE.
- IDLE: pc held at 0, `instr_valid`=0. `start`=1 at an edge moves to RUN; no fetch on that edge.
- RUN, per edge, evaluated in priority order:
  - Branch: `branch_abs` or `branch_rel`, only honoured when `instr_valid`=1. pc <= target, `instr_valid` <= 0, which flushes the word at pc. `branch_abs` wins if both are asserted. A branch overrides `stall`.
  - Stall: `stall`=1 and no branch. pc, `instr_out`, `instr_pc`, `instr_valid` all hold.
  - Halt: `mem_instr` == HALT_WORD. Go to HALT, `instr_valid` <= 0, pc holds at the halt address, `instr_out` holds. The halt word is never issued.
  - Normal fetch: `instr_out` <= `mem_instr`, `instr_pc` <= pc, `instr_valid` <= 1, pc <= pc+1.
- HALT: `halted`=1. pc, `instr_out`, `instr_pc` frozen; `instr_valid`=0. `start`, `stall` and branches are ignored. Exit only by reset.
- Arithmetic is modulo 2^p_size. pc+1 wraps from 2^p_size-1 to 0. Relative target = (`instr_pc` + `branch_offset`) mod 2^p_size, with the offset sign-extended to p_size. No overflow flag.
- Reset mid-operation (any state, any cycle) immediately forces all reset values; any in-flight instruction is discarded.

## Timing
- Reset values: pc=0, `address`=0, `instr_out`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0, state IDLE.
- `address` is combinational from pc. There is no registered read; the memory path is combinational within the same cycle.
- Fetch latency: pc=A at cycle n gives `instr_out`=mem[A] and `instr_valid`=1 from the edge ending cycle n.
- First valid instruction: two edges after `start` is sampled (one edge to RUN, one edge to fetch mem[0]).
- Branch penalty: exactly one bubble cycle (`instr_valid`=0). mem[target] appears on the second edge after the branch is sampled.
- Throughput: one instruction per cycle when there is no stall, branch or halt.
- `halted` is registered; it asserts on the same edge on which `instr_valid` drops for halt.

## Test plan
- Reset/start: assert `reset` mid-cycle; all outputs go to reset values immediately. Release and pulse `start`. Then `address`=0 for one cycle, and on the next edge `instr_out`=mem[0], `instr_pc`=0, `instr_valid`=1, `address`=1.
- Sequential wrap: p_size=6, mem filled with non-halt words, run 70 cycles. `instr_pc` runs 0..63 then 0..5 with no bubbles.
- Stall: assert `stall` for 3 cycles while `instr_pc`=4. `instr_out`, `instr_pc`=4 and `address`=5 hold. Fetch of mem[5] occurs on the first edge after release.
- Branches: `branch_abs` with target 0x20 while `instr_pc`=3 gives one bubble, then `instr_pc`=0x20. `branch_rel` with offset 6'h3E (-2) while `instr_pc`=1 gives target 0x3F. Asserting both together goes to `branch_target`. A branch while `stall`=1 is still taken.
- Halt: mem[7]=HALT_WORD. After `instr_pc`=6 issues, `halted`=1, `instr_valid`=0, `address`=7 frozen. `start` and `branch_abs` are then ignored for 10 cycles. `reset` returns to IDLE.
- Reset during a branch bubble: assert `reset` on the bubble cycle. Outputs are at reset values and no fetch occurs until `start`.
